barrel_shifter_ctrl: RTL and testbench

Scheduler and configuration controller for the `barrel_shifter` interconnect stage.
- Arbitrates round-robin among `NOF_REQ` requesters (PE-group sequencers) that want a shift operation.
- Registers the winner's shift amount and group size and drives the shifter's configuration for one issue cycle.
- Tracks the shifter pipeline latency and returns a completion pulse tagged with the owner ID.
- Sits between the PE sequencers and the `barrel_shifter` datapath; exactly one operation is in flight at a time.

---
 rtl/barrel_shifter_pkg.sv | 26 ++
 rtl/barrel_shifter_ctrl_rr_arbiter.sv | 31 +++
 rtl/barrel_shifter_ctrl.sv | 151 +++++++++++++++
 tb/tb_barrel_shifter_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the barrel_shifter interconnect stage: geometry,
// controller state encoding and the group-size shift masking rule.
package barrel_shifter_pkg;

  localparam int unsigned NOF_PES          = 16;
  localparam int unsigned NOF_LEVELS       = $clog2(NOF_PES);
  localparam int unsigned GROUP_SIZE_WIDTH = NOF_LEVELS + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } ctrl_state_t;

  // Shift taken modulo the group size; g is assumed already clamped to NOF_LEVELS.
  function automatic logic [NOF_LEVELS-1:0] eff_shift(
    input logic [NOF_LEVELS-1:0]       shift,
    input logic [GROUP_SIZE_WIDTH-1:0] g
  );
    logic [GROUP_SIZE_WIDTH-1:0] w_mask;
    w_mask = (GROUP_SIZE_WIDTH'(1) << g) - GROUP_SIZE_WIDTH'(1);
    return shift & w_mask[NOF_LEVELS-1:0];
  endfunction

endpackage

// File: rtl/barrel_shifter_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the
// pointer, wrapping around. Shared by the interconnect schedulers.
module rr_arbiter #(
  parameter int unsigned NOF_REQ  = 4,
  parameter int unsigned ID_WIDTH = $clog2(NOF_REQ)
) (
  input  logic [NOF_REQ-1:0]  i_req,
  input  logic [ID_WIDTH-1:0] i_ptr,
  output logic [NOF_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_idx
);

  logic                w_found;
  logic [ID_WIDTH-1:0] w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int unsigned k = 0; k < NOF_REQ; k++) begin
      w_pos = ID_WIDTH'((32'(i_ptr) + k) % NOF_REQ);
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
      end
    end
  end

endmodule

// File: rtl/barrel_shifter_ctrl.sv
// Round-robin scheduler and configuration controller for the barrel_shifter
// datapath; one operation in flight, completion returned with its owner ID.
module barrel_shifter_ctrl #(
  parameter int unsigned NOF_PES          = 16,
  parameter int unsigned NOF_LEVELS       = $clog2(NOF_PES),
  parameter int unsigned GROUP_SIZE_WIDTH = NOF_LEVELS + 1,
  parameter int unsigned NOF_REQ          = 4,
  parameter int unsigned REQ_ID_WIDTH     = $clog2(NOF_REQ),
  parameter int unsigned SHIFTER_LATENCY  = NOF_LEVELS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NOF_REQ-1:0]                  req_valid,
  output logic [NOF_REQ-1:0]                  req_ready,
  input  logic [NOF_REQ*NOF_LEVELS-1:0]       req_shift,
  input  logic [NOF_REQ*GROUP_SIZE_WIDTH-1:0] req_group_log2,
  output logic                                sh_valid,
  output logic [NOF_LEVELS-1:0]               sh_shift,
  output logic [GROUP_SIZE_WIDTH-1:0]         sh_group_log2,
  output logic                                done_valid,
  output logic [REQ_ID_WIDTH-1:0]             done_id,
  output logic                                cfg_err,
  output logic                                busy
);
  import barrel_shifter_pkg::*;

  localparam int unsigned       CNT_W    = $clog2(SHIFTER_LATENCY + 1);
  localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(SHIFTER_LATENCY - 1);

  ctrl_state_t                 r_state;
  ctrl_state_t                 w_state_nxt;
  logic [REQ_ID_WIDTH-1:0]     r_rr_ptr;
  logic [REQ_ID_WIDTH-1:0]     r_owner;
  logic [NOF_LEVELS-1:0]       r_shift;
  logic [GROUP_SIZE_WIDTH-1:0] r_group;
  logic                        r_err;
  logic [CNT_W-1:0]            r_lat_cnt;

  logic [NOF_REQ-1:0]          w_gnt;
  logic [REQ_ID_WIDTH-1:0]     w_gnt_idx;
  logic                        w_accept;
  logic [NOF_LEVELS-1:0]       w_shift_sel;
  logic [GROUP_SIZE_WIDTH-1:0] w_group_sel;
  logic [GROUP_SIZE_WIDTH-1:0] w_group_eff;
  logic                        w_err;

  rr_arbiter #(
    .NOF_REQ  (NOF_REQ),
    .ID_WIDTH (REQ_ID_WIDTH)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_gnt),
    .o_idx   (w_gnt_idx)
  );

  always_comb begin
    w_shift_sel = '0;
    w_group_sel = '0;
    for (int unsigned i = 0; i < NOF_REQ; i++) begin
      if (w_gnt[i]) begin
        w_shift_sel = req_shift[i*NOF_LEVELS +: NOF_LEVELS];
        w_group_sel = req_group_log2[i*GROUP_SIZE_WIDTH +: GROUP_SIZE_WIDTH];
      end
    end
  end

  assign w_accept    = (r_state == IDLE) && (|w_gnt);
  assign w_err       = w_group_sel > GROUP_SIZE_WIDTH'(NOF_LEVELS);
  assign w_group_eff = w_err ? GROUP_SIZE_WIDTH'(NOF_LEVELS) : w_group_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_shift   <= '0;
      r_group   <= '0;
      r_err     <= 1'b0;
      r_lat_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_owner <= w_gnt_idx;
        r_shift <= eff_shift(w_shift_sel, w_group_eff);
        r_group <= w_group_eff;
        r_err   <= w_err;
      end
      case (r_state)
        ISSUE: r_lat_cnt <= LAT_LOAD;
        WAIT: begin
          if (r_lat_cnt != '0) begin
            r_lat_cnt <= r_lat_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          r_rr_ptr <= (r_owner == REQ_ID_WIDTH'(NOF_REQ - 1)) ? '0
                                                              : r_owner + REQ_ID_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = '0;
    sh_valid      = 1'b0;
    sh_shift      = '0;
    sh_group_log2 = '0;
    cfg_err       = 1'b0;
    done_valid    = 1'b0;
    done_id       = '0;
    case (r_state)
      IDLE: begin
        req_ready = w_gnt;
        if (w_accept) begin
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        sh_valid      = 1'b1;
        sh_shift      = r_shift;
        sh_group_log2 = r_group;
        cfg_err       = r_err;
        w_state_nxt   = (SHIFTER_LATENCY > 1) ? WAIT : DONE;
      end
      WAIT: begin
        // Exit on 1: the final decrement and the move to DONE share a cycle.
        if (r_lat_cnt <= CNT_W'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done_valid  = 1'b1;
        done_id     = r_owner;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_barrel_shifter_ctrl.sv
// Self-checking bench for barrel_shifter_ctrl: directed scenarios plus a
// randomized run checked against a cycle-history scheduling model.
module tb_barrel_shifter_ctrl;

  localparam int NQ  = 4;
  localparam int NL  = 4;
  localparam int GW  = 5;
  localparam int LAT = 4;
  localparam int HN  = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NQ-1:0]     req_valid = '0;
  logic [NQ-1:0]     req_ready;
  logic [NQ*NL-1:0]  req_shift = '0;
  logic [NQ*GW-1:0]  req_group_log2 = '0;
  logic              sh_valid;
  logic [NL-1:0]     sh_shift;
  logic [GW-1:0]     sh_group_log2;
  logic              done_valid;
  logic [1:0]        done_id;
  logic              cfg_err;
  logic              busy;

  always #5 clk = ~clk;

  barrel_shifter_ctrl #(
    .NOF_PES         (16),
    .NOF_REQ         (NQ),
    .SHIFTER_LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_shift      (req_shift),
    .req_group_log2 (req_group_log2),
    .sh_valid       (sh_valid),
    .sh_shift       (sh_shift),
    .sh_group_log2  (sh_group_log2),
    .done_valid     (done_valid),
    .done_id        (done_id),
    .cfg_err        (cfg_err),
    .busy           (busy)
  );

  typedef struct {int cyc; int id; int shift; int g; int err;} ev_t;
  typedef struct {int shift; int g;} op_t;

  ev_t acc_q[$];
  ev_t sh_q[$];
  ev_t done_q[$];
  op_t op_q[NQ][$];

  int               cyc = 0;
  int               vhist[HN];
  logic [NQ*NL-1:0] shist[HN];
  logic [NQ*GW-1:0] ghist[HN];
  bit               bhist[HN];
  int               n_multi = 0, n_ready_busy = 0, n_stray_err = 0;
  int               acc_seen = 0;
  bit               wd_en = 1'b0;
  int               n_checks = 0, n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (!rst && cyc < HN) begin
      vhist[cyc] = int'(req_valid);
      shist[cyc] = req_shift;
      ghist[cyc] = req_group_log2;
      bhist[cyc] = busy;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0) n_multi++;
      if (busy && req_ready != '0) n_ready_busy++;
      if (cfg_err && !sh_valid) n_stray_err++;
      for (int i = 0; i < NQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.cyc = cyc; e.id = i; e.err = 0;
          e.shift = int'(req_shift[NL*i +: NL]);
          e.g = int'(req_group_log2[GW*i +: GW]);
          acc_q.push_back(e);
        end
      end
      if (sh_valid) begin
        e.cyc = cyc; e.id = 0; e.shift = int'(sh_shift);
        e.g = int'(sh_group_log2); e.err = int'(cfg_err);
        sh_q.push_back(e);
      end
      if (done_valid) begin
        e.cyc = cyc; e.id = int'(done_id); e.shift = 0; e.g = 0; e.err = 0;
        done_q.push_back(e);
      end
    end
  end

  // Reference rules: group log2 clamped to NL, shift reduced modulo the group size.
  function automatic int ref_g(int g);
    return (g > NL) ? NL : g;
  endfunction
  function automatic int ref_shift(int s, int g);
    return s % (1 << ref_g(g));
  endfunction
  function automatic int ref_err(int g);
    return (g > NL) ? 1 : 0;
  endfunction

  function automatic bit ops_empty();
    for (int i = 0; i < NQ; i++) if (op_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    while (acc_seen < acc_q.size()) begin
      void'(op_q[acc_q[acc_seen].id].pop_front());
      acc_seen++;
    end
    for (int i = 0; i < NQ; i++) begin
      if (op_q[i].size() != 0) begin
        req_valid[i] = wd_en ? ($urandom_range(3) != 0) : 1'b1;
        req_shift[NL*i +: NL] = NL'(op_q[i][0].shift);
        req_group_log2[GW*i +: GW] = GW'(op_q[i][0].g);
      end else begin
        req_valid[i] = 1'b0;
        req_shift[NL*i +: NL] = NL'($urandom);
        req_group_log2[GW*i +: GW] = GW'($urandom);
      end
    end
  endtask

  task automatic run_idle(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (ops_empty() && !busy) begin
        timed_out = 1'b0;
        break;
      end
    end
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    wd_en = 1'b0;
    for (int i = 0; i < NQ; i++) op_q[i].delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    acc_q.delete(); sh_q.delete(); done_q.delete();
    acc_seen = 0;
  endtask

  task automatic test_reset();
    logic [18:0] v;
    do_reset();
    v = {sh_valid, sh_shift, sh_group_log2, done_valid, done_id, cfg_err, busy, req_ready};
    n_checks++; if (v !== '0) $display("FAIL reset_outputs got %h want 0", v); else n_pass++;
    req_valid = 4'b0110;
    #1;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL reset_ptr_grant got %b want 0010", req_ready); else n_pass++;
    req_valid = '0;
  endtask

  task automatic test_single();
    bit to;
    int t;
    op_t o;
    do_reset();
    o.shift = 5; o.g = 4; op_q[0].push_back(o);
    run_idle(40, to);
    n_checks++; if (to) $display("FAIL single_timeout got 1 want 0"); else n_pass++;
    t = acc_q[0].cyc;
    n_checks++; if (acc_q.size() != 1 || acc_q[0].id != 0) $display("FAIL single_accept got n=%0d id=%0d want n=1 id=0", acc_q.size(), acc_q[0].id); else n_pass++;
    n_checks++; if (sh_q.size() != 1 || sh_q[0].cyc != t + 1) $display("FAIL single_sh_time got n=%0d cyc=%0d want n=1 cyc=%0d", sh_q.size(), sh_q[0].cyc, t + 1); else n_pass++;
    n_checks++; if (sh_q[0].shift != 5 || sh_q[0].g != 4 || sh_q[0].err != 0) $display("FAIL single_cfg got s=%0d g=%0d e=%0d want s=5 g=4 e=0", sh_q[0].shift, sh_q[0].g, sh_q[0].err); else n_pass++;
    n_checks++; if (done_q.size() != 1 || done_q[0].cyc != t + 5 || done_q[0].id != 0) $display("FAIL single_done got n=%0d cyc=%0d id=%0d want n=1 cyc=%0d id=0", done_q.size(), done_q[0].cyc, done_q[0].id, t + 5); else n_pass++;
    n_checks++; if (bhist[t + 5] !== 1'b1 || bhist[t + 6] !== 1'b0) $display("FAIL single_busy got %b%b want 10", bhist[t + 5], bhist[t + 6]); else n_pass++;
  endtask

  task automatic test_all_four();
    bit to;
    op_t o;
    int es[NQ], eg[NQ];
    do_reset();
    for (int i = 0; i < NQ; i++) begin
      o.shift = $urandom_range(15); o.g = $urandom_range(NL);
      es[i] = ref_shift(o.shift, o.g); eg[i] = ref_g(o.g);
      op_q[i].push_back(o);
    end
    run_idle(100, to);
    n_checks++; if (to || acc_q.size() != NQ || done_q.size() != NQ) $display("FAIL all4_count got to=%0d acc=%0d done=%0d want 0 4 4", to, acc_q.size(), done_q.size()); else n_pass++;
    for (int i = 0; i < NQ; i++) begin
      n_checks++; if (acc_q[i].id != i || done_q[i].id != i) $display("FAIL all4_order got acc=%0d done=%0d want %0d", acc_q[i].id, done_q[i].id, i); else n_pass++;
      n_checks++; if (sh_q[i].shift != es[i] || sh_q[i].g != eg[i]) $display("FAIL all4_cfg got s=%0d g=%0d want s=%0d g=%0d", sh_q[i].shift, sh_q[i].g, es[i], eg[i]); else n_pass++;
      if (i > 0) begin
        n_checks++; if (acc_q[i].cyc - acc_q[i-1].cyc != LAT + 2) $display("FAIL all4_spacing got %0d want %0d", acc_q[i].cyc - acc_q[i-1].cyc, LAT + 2); else n_pass++;
      end
    end
    for (int i = NQ - 1; i >= 0; i--) begin
      o.shift = 1; o.g = 1; op_q[i].push_back(o);
    end
    run_idle(100, to);
    n_checks++; if (to || acc_q.size() != 2 * NQ || acc_q[NQ].id != 0) $display("FAIL all4_ptr_wrap got to=%0d n=%0d id=%0d want 0 8 0", to, acc_q.size(), acc_q[NQ].id); else n_pass++;
  endtask

  task automatic test_mask_clamp();
    bit to;
    op_t o;
    int ts[6] = '{13, 7, 9, 11, 15, 6};
    int tg[6] = '{2, 0, 7, 5, 4, 1};
    int es[6] = '{1, 0, 9, 11, 15, 0};
    int eg[6] = '{2, 0, 4, 4, 4, 1};
    int ee[6] = '{0, 0, 1, 1, 0, 0};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      o.shift = ts[k]; o.g = tg[k]; op_q[0].push_back(o);
    end
    run_idle(150, to);
    n_checks++; if (to || sh_q.size() != 6) $display("FAIL mask_count got to=%0d n=%0d want 0 6", to, sh_q.size()); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (sh_q[k].shift != es[k] || sh_q[k].g != eg[k] || sh_q[k].err != ee[k])
        $display("FAIL mask_case%0d got s=%0d g=%0d e=%0d want s=%0d g=%0d e=%0d", k, sh_q[k].shift, sh_q[k].g, sh_q[k].err, es[k], eg[k], ee[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_wait();
    bit to;
    int t, r;
    op_t o;
    logic [18:0] v;
    do_reset();
    o.shift = 3; o.g = 3; op_q[0].push_back(o);
    for (int n = 0; n < 20 && acc_q.size() == 0; n++) tick();
    t = acc_q[0].cyc;
    tick();
    tick();
    n_checks++; if (cyc != t + 3 || busy !== 1'b1) $display("FAIL rstw_setup got cyc=%0d busy=%b want cyc=%0d busy=1", cyc, busy, t + 3); else n_pass++;
    rst = 1'b1;
    #1;
    v = {sh_valid, sh_shift, sh_group_log2, done_valid, done_id, cfg_err, busy, req_ready};
    n_checks++; if (v !== '0) $display("FAIL rstw_outputs got %h want 0", v); else n_pass++;
    repeat (4) @(posedge clk);
    #1;
    o.shift = 6; o.g = 2; op_q[2].push_back(o);
    req_shift[NL*2 +: NL] = NL'(6);
    req_group_log2[GW*2 +: GW] = GW'(2);
    req_valid = 4'b0100;
    rst = 1'b0;
    r = cyc;
    run_idle(40, to);
    n_checks++; if (to || acc_q.size() != 2 || acc_q[1].id != 2 || acc_q[1].cyc != r) $display("FAIL rstw_regrant got n=%0d id=%0d cyc=%0d want n=2 id=2 cyc=%0d", acc_q.size(), acc_q[1].id, acc_q[1].cyc, r); else n_pass++;
    n_checks++; if (done_q.size() != 1 || done_q[0].id != 2) $display("FAIL rstw_no_done got n=%0d id=%0d want n=1 id=2", done_q.size(), done_q[0].id); else n_pass++;
    n_checks++; if (sh_q.size() != 2 || sh_q[1].shift != 2 || sh_q[1].g != 2) $display("FAIL rstw_cfg got n=%0d s=%0d g=%0d want n=2 s=2 g=2", sh_q.size(), sh_q[1].shift, sh_q[1].g); else n_pass++;
  endtask

  task automatic test_fairness();
    bit to;
    op_t o;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      o.shift = $urandom_range(15); o.g = $urandom_range(7); op_q[1].push_back(o);
      o.shift = $urandom_range(15); o.g = $urandom_range(7); op_q[3].push_back(o);
    end
    run_idle(200, to);
    n_checks++; if (to || acc_q.size() != 10) $display("FAIL fair_count got to=%0d n=%0d want 0 10", to, acc_q.size()); else n_pass++;
    for (int k = 0; k < 10; k++) begin
      n_checks++; if (acc_q[k].id != ((k % 2 == 0) ? 1 : 3)) $display("FAIL fair_order%0d got %0d want %0d", k, acc_q[k].id, (k % 2 == 0) ? 1 : 3); else n_pass++;
      if (k > 0) begin
        n_checks++; if (acc_q[k].cyc - acc_q[k-1].cyc != LAT + 2) $display("FAIL fair_gap%0d got %0d want %0d", k, acc_q[k].cyc - acc_q[k-1].cyc, LAT + 2); else n_pass++;
      end
    end
  endtask

  // Replays the recorded request history through the scheduling rules and
  // compares every predicted grant, issue and completion with what was seen.
  task automatic test_random();
    bit to;
    op_t o;
    int s0, e, c, k, ptr, id, p, s, g;
    do_reset();
    s0 = cyc;
    for (int n = 0; n < 30; n++) begin
      o.shift = $urandom_range(15); o.g = $urandom_range(7);
      op_q[$urandom_range(NQ - 1)].push_back(o);
    end
    wd_en = 1'b1;
    run_idle(1500, to);
    wd_en = 1'b0;
    e = cyc;
    n_checks++; if (to) $display("FAIL rand_timeout got 1 want 0"); else n_pass++;
    ptr = 0; k = 0; c = s0;
    while (c < e) begin
      if (vhist[c] != 0) begin
        id = -1;
        for (int j = 0; j < NQ; j++) begin
          p = (ptr + j) % NQ;
          if (id < 0 && ((vhist[c] >> p) & 1) != 0) id = p;
        end
        s = int'(shist[c][NL*id +: NL]);
        g = int'(ghist[c][GW*id +: GW]);
        n_checks++; if (acc_q[k].cyc != c || acc_q[k].id != id) $display("FAIL rand_grant%0d got cyc=%0d id=%0d want cyc=%0d id=%0d", k, acc_q[k].cyc, acc_q[k].id, c, id); else n_pass++;
        n_checks++;
        if (sh_q[k].cyc != c + 1 || sh_q[k].shift != ref_shift(s, g) || sh_q[k].g != ref_g(g) || sh_q[k].err != ref_err(g))
          $display("FAIL rand_issue%0d got cyc=%0d s=%0d g=%0d e=%0d want cyc=%0d s=%0d g=%0d e=%0d", k, sh_q[k].cyc, sh_q[k].shift, sh_q[k].g, sh_q[k].err, c + 1, ref_shift(s, g), ref_g(g), ref_err(g));
        else n_pass++;
        n_checks++; if (done_q[k].cyc != c + 1 + LAT || done_q[k].id != id) $display("FAIL rand_done%0d got cyc=%0d id=%0d want cyc=%0d id=%0d", k, done_q[k].cyc, done_q[k].id, c + 1 + LAT, id); else n_pass++;
        ptr = (id + 1) % NQ;
        k++;
        c += LAT + 2;
      end else begin
        c++;
      end
    end
    n_checks++; if (k != 30 || acc_q.size() != k || sh_q.size() != k || done_q.size() != k) $display("FAIL rand_totals got model=%0d acc=%0d sh=%0d done=%0d want 30 each", k, acc_q.size(), sh_q.size(), done_q.size()); else n_pass++;
  endtask

  task automatic test_protocol();
    n_checks++; if (n_multi != 0) $display("FAIL proto_onehot got %0d want 0", n_multi); else n_pass++;
    n_checks++; if (n_ready_busy != 0) $display("FAIL proto_ready_busy got %0d want 0", n_ready_busy); else n_pass++;
    n_checks++; if (n_stray_err != 0) $display("FAIL proto_cfg_err got %0d want 0", n_stray_err); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_mask_clamp();
    test_reset_wait();
    test_fairness();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
